// File: rtl/tmr_arbiter.sv
// Shares one timer among N_REQ requesters: arbitrates, loads the winner's config, sequences clear/enable, routes done.
// Optional build macro TMR_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module tmr_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_mode,
  input  logic [N_REQ*CNT_W-1:0] req_time,
  output logic [N_REQ-1:0]       req_grant,
  output logic [N_REQ-1:0]       req_done,
  output logic                   busy,
  output logic                   tmr_enable,
  output logic                   tmr_mode,
  output logic [CNT_W-1:0]       tmr_time_count,
  output logic                   tmr_clear,
  input  logic                   tmr_done
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RELEASE} state_t;

  state_t             state;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      win;
  logic               any;
  logic [N_REQ-1:0]   win_onehot;
  logic [CNT_W-1:0]   win_time;

`ifdef TMR_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win = IW'(i);
        any = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  // First asserted request at or above ptr, wrapping to 0.
  always_comb begin
    int j;
    win = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!any && req[j]) begin
        win = IW'(j);
        any = 1'b1;
      end
    end
  end
`endif

  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win;
  assign win_time   = req_time[int'(win)*CNT_W +: CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= '0;
      req_grant      <= '0;
      req_done       <= '0;
      busy           <= 1'b0;
      tmr_enable     <= 1'b0;
      tmr_mode       <= 1'b0;
      tmr_time_count <= '0;
      tmr_clear      <= 1'b0;
`ifndef TMR_ARB_FIXED_PRIO_EN
      ptr            <= '0;
`endif
    end else begin
      tmr_clear <= 1'b0;
      req_done  <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            owner          <= win;
            req_grant      <= win_onehot;
            tmr_mode       <= req_mode[win];
            tmr_time_count <= win_time;
            tmr_clear      <= 1'b1;
            busy           <= 1'b1;
            state          <= LOAD;
          end
        end
        LOAD: begin
          // A zero interval completes immediately without ever enabling the timer.
          if (tmr_time_count == '0) begin
            req_done <= req_grant;
            state    <= RELEASE;
          end else begin
            tmr_enable <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          // Done outranks a simultaneous release so the final pulse is never lost.
          if (tmr_done) begin
            req_done <= req_grant;
            if (!tmr_mode || !req[owner]) begin
              tmr_enable <= 1'b0;
              state      <= RELEASE;
            end
          end else if (!req[owner]) begin
            tmr_enable <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          tmr_clear  <= 1'b1;
          tmr_enable <= 1'b0;
          req_grant  <= '0;
          busy       <= 1'b0;
`ifndef TMR_ARB_FIXED_PRIO_EN
          ptr        <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tmr_arbiter.sv
// Directed bench for tmr_arbiter: expected grants/dones go into queues, a negedge monitor pops and compares.
module tb_tmr_arbiter;
  localparam int N_REQ = 4;
  localparam int CNT_W = 24;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       req_mode;
  logic [N_REQ*CNT_W-1:0] req_time;
  logic [N_REQ-1:0]       req_grant;
  logic [N_REQ-1:0]       req_done;
  logic                   busy;
  logic                   tmr_enable;
  logic                   tmr_mode;
  logic [CNT_W-1:0]       tmr_time_count;
  logic                   tmr_clear;
  logic                   tmr_done;

  int total = 0;
  int bad   = 0;
  int grant_q[$];
  logic [N_REQ-1:0] done_q[$];
  logic [N_REQ-1:0] prev_grant = '0;

  tmr_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_time(req_time),
    .req_grant(req_grant), .req_done(req_done), .busy(busy),
    .tmr_enable(tmr_enable), .tmr_mode(tmr_mode), .tmr_time_count(tmr_time_count),
    .tmr_clear(tmr_clear), .tmr_done(tmr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every new grant and every done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant_onehot0", 32'($onehot0(req_grant)), 32'd1);
      chk("done_owner_only", 32'(req_done & ~req_grant), 32'd0);
      if (req_grant != '0 && req_grant != prev_grant) begin
        if (grant_q.size() == 0) chk("grant_unexpected", 32'(req_grant), 32'd0);
        else chk("grant_order", 32'(req_grant), 32'(1 << grant_q.pop_front()));
      end
      if (req_done != '0) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'(req_done), 32'd0);
        else chk("done_vec", 32'(req_done), 32'(done_q.pop_front()));
      end
    end
    prev_grant = req_grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic mode, input int t);
    req_mode[idx] = mode;
    req_time[idx*CNT_W +: CNT_W] = CNT_W'(t);
    req[idx] = 1'b1;
  endtask

  // Serve one one-shot owner: wait for grant, pulse tmr_done once enabled (unless zero count), drop req on done.
  task automatic serve();
    int n;
    int idx;
    logic zero;
    n = 0;
    while (req_grant == '0 && n < 20) begin tick(); n++; end
    if (n == 20) begin chk("serve_grant_timeout", 32'd0, 32'd1); return; end
    idx = 0;
    for (int i = 0; i < N_REQ; i++) if (req_grant[i]) idx = i;
    zero = (tmr_time_count == '0);
    if (!zero) begin
      n = 0;
      while (!tmr_enable && n < 5) begin tick(); n++; end
      tick();
      tmr_done = 1'b1;
    end
    n = 0;
    tick();
    tmr_done = 1'b0;
    while (req_done == '0 && n < 5) begin
      if (zero) chk("zero_no_enable", 32'(tmr_enable), 32'd0);
      tick(); n++;
    end
    if (zero) chk("zero_no_enable", 32'(tmr_enable), 32'd0);
    chk("serve_done_seen", 32'(req_done[idx]), 32'd1);
    req[idx] = 1'b0;
    n = 0;
    while (req_grant != '0 && n < 5) begin tick(); n++; end
    chk("serve_released", 32'(req_grant), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_mode = '0; req_time = '0; tmr_done = 1'b0;
    repeat (2) tick();
    chk("rst_grant", 32'(req_grant), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_enable", 32'(tmr_enable), 0);
    chk("rst_mode", 32'(tmr_mode), 0);
    chk("rst_count", 32'(tmr_time_count), 0);
    chk("rst_clear", 32'(tmr_clear), 0);
    rst = 1'b0;
    tick();

    // Single one-shot, time 100.
    set_req(1, 1'b0, 100);
    grant_q.push_back(1); done_q.push_back(4'b0010);
    tick();
    chk("os_grant", 32'(req_grant), 32'b0010);
    chk("os_clear", 32'(tmr_clear), 1);
    chk("os_enable_early", 32'(tmr_enable), 0);
    chk("os_busy", 32'(busy), 1);
    chk("os_count", 32'(tmr_time_count), 100);
    req_time[1*CNT_W +: CNT_W] = CNT_W'(7);
    tick();
    chk("os_enable", 32'(tmr_enable), 1);
    chk("os_clear_low", 32'(tmr_clear), 0);
    repeat (99) tick();
    tmr_done = 1'b1;
    tick();
    tmr_done = 1'b0;
    chk("os_done", 32'(req_done), 32'b0010);
    chk("os_enable_drop", 32'(tmr_enable), 0);
    chk("os_count_kept", 32'(tmr_time_count), 100);
    req = '0;
    tick();
    chk("os_done_once", 32'(req_done), 0);
    chk("os_rel_clear", 32'(tmr_clear), 1);
    chk("os_rel_grant", 32'(req_grant), 0);
    chk("os_rel_busy", 32'(busy), 0);
    tick();
    chk("os_clear_pulse", 32'(tmr_clear), 0);

    // Contention from pointer 0.
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 1'b0, 3); set_req(2, 1'b0, 3); set_req(3, 1'b0, 3);
    grant_q.push_back(0); grant_q.push_back(2); grant_q.push_back(3);
    done_q.push_back(4'b0001); done_q.push_back(4'b0100); done_q.push_back(4'b1000);
    repeat (3) serve();

    // Auto-reload, three done pulses then release.
    tick();
    set_req(2, 1'b1, 10);
    grant_q.push_back(2);
    repeat (3) done_q.push_back(4'b0100);
    repeat (2) tick();
    chk("ar_enable", 32'(tmr_enable), 1);
    chk("ar_mode", 32'(tmr_mode), 1);
    for (int k = 0; k < 3; k++) begin
      tmr_done = 1'b1; tick(); tmr_done = 1'b0;
      chk("ar_done", 32'(req_done), 32'b0100);
      chk("ar_stay_enabled", 32'(tmr_enable), 1);
      repeat (3) tick();
    end
    req[2] = 1'b0;
    tick();
    chk("ar_enable_drop", 32'(tmr_enable), 0);
    tick();
    chk("ar_rel_clear", 32'(tmr_clear), 1);
    chk("ar_rel_grant", 32'(req_grant), 0);

    // One-shot abort: no done, pointer advances to 2.
    tick();
    set_req(1, 1'b0, 50);
    grant_q.push_back(1);
    repeat (5) tick();
    req[1] = 1'b0;
    tick();
    chk("ab_enable_drop", 32'(tmr_enable), 0);
    chk("ab_no_done", 32'(req_done), 0);
    tick();
    chk("ab_rel_clear", 32'(tmr_clear), 1);

    // Zero counts on 0 and 2: order shows the pointer (RR) or priority (fixed).
    set_req(0, 1'b0, 0); set_req(2, 1'b0, 0);
`ifdef TMR_ARB_FIXED_PRIO_EN
    grant_q.push_back(0); grant_q.push_back(2);
    done_q.push_back(4'b0001); done_q.push_back(4'b0100);
`else
    grant_q.push_back(2); grant_q.push_back(0);
    done_q.push_back(4'b0100); done_q.push_back(4'b0001);
`endif
    repeat (2) serve();

    // Auto-reload with done and release in the same cycle.
    tick();
    set_req(3, 1'b1, 5);
    grant_q.push_back(3); done_q.push_back(4'b1000);
    repeat (3) tick();
    tmr_done = 1'b1; req[3] = 1'b0;
    tick();
    tmr_done = 1'b0;
    chk("co_done", 32'(req_done), 32'b1000);
    chk("co_enable_drop", 32'(tmr_enable), 0);
    tick();
    chk("co_rel_clear", 32'(tmr_clear), 1);
    chk("co_done_once", 32'(req_done), 0);

    // Stale done while idle.
    tmr_done = 1'b1;
    repeat (3) tick();
    tmr_done = 1'b0;
    chk("stale_busy", 32'(busy), 0);
    chk("stale_done", 32'(req_done), 0);

    // Reset in the middle of RUN.
    set_req(1, 1'b0, 20);
    grant_q.push_back(1);
    repeat (4) tick();
    chk("mr_running", 32'(tmr_enable), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; req = '0;
    chk("mr_grant", 32'(req_grant), 0);
    chk("mr_enable", 32'(tmr_enable), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_count", 32'(tmr_time_count), 0);
    chk("mr_clear", 32'(tmr_clear), 0);
    chk("mr_done", 32'(req_done), 0);
    tick();
    set_req(3, 1'b0, 4);
    grant_q.push_back(3); done_q.push_back(4'b1000);
    serve();

    repeat (3) tick();
    chk("grant_q_empty", 32'(grant_q.size()), 0);
    chk("done_q_empty", 32'(done_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
